key_sched_ctrl: RTL and testbench

Sequencer for the round-key datapath. On a start command it latches a 128-bit key and streams round keys K_1..K_ROUNDS to the cipher core, three per beat. Forward order is used for encryption and reverse order for decryption. Output uses a valid/ready handshake, so the cipher core can stall the schedule. The block replaces free-running enable-driven key generation with a start/busy/done controlled unit.

---
 rtl/key_sched_pkg.sv | 35 +++
 rtl/key_sched_lane.sv | 13 +
 rtl/key_sched_ctrl.sv | 125 ++++++++++++
 tb/tb_key_sched_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/key_sched_pkg.sv
// Shared types, sizes and the round-key byte function for the key schedule sequencer.
package key_sched_pkg;

  localparam int unsigned ROUNDS_DEF = 96;
  localparam int unsigned KPB        = 3;
  localparam int unsigned KEY_W      = 128;
  localparam int unsigned RK_W       = 8;
  localparam int unsigned RND_W      = 7;
  localparam int unsigned BEAT_W     = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  // One output beat: base round index plus the three round keys it carries.
  typedef struct packed {
    logic [RND_W-1:0] round;
    logic [RK_W-1:0]  rk0;
    logic [RK_W-1:0]  rk1;
    logic [RK_W-1:0]  rk2;
  } beat_t;

  // K_r = {0, r} ^ key_byte(j), j = (r[3:0] - 1) mod 16, key bytes numbered MSB-first.
  function automatic logic [RK_W-1:0] rk_byte(input logic [KEY_W-1:0] key,
                                              input logic [RND_W-1:0] r);
    logic [3:0] j;
    logic [3:0] sel;
    j       = r[3:0] - 4'd1;
    sel     = 4'd15 - j;
    rk_byte = {1'b0, r} ^ key[{sel, 3'b000} +: RK_W];
  endfunction

endpackage

// File: rtl/key_sched_lane.sv
// Combinational round-key generator for a single lane.
module key_sched_lane
  import key_sched_pkg::*;
(
  input  logic [KEY_W-1:0] key,
  input  logic [RND_W-1:0] round,
  output logic [RK_W-1:0]  rk_c
);

  // Round key for the requested round under the given key.
  assign rk_c = rk_byte(key, round);

endmodule

// File: rtl/key_sched_ctrl.sv
// Start/busy/done sequencer streaming three round keys per valid/ready beat.
module key_sched_ctrl
  import key_sched_pkg::*;
#(
  parameter int unsigned ROUNDS = ROUNDS_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              mode,
  input  logic [KEY_W-1:0]  key_in,
  input  logic              abort,
  input  logic              rk_ready,
  output logic              rk_valid,
  output logic [RK_W-1:0]   rk0,
  output logic [RK_W-1:0]   rk1,
  output logic [RK_W-1:0]   rk2,
  output logic [RND_W-1:0]  rk_round,
  output logic              busy,
  output logic              done
);

  localparam int unsigned       BEATS     = ROUNDS / KPB;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  state_e             state_q, state_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic               mode_q, mode_d;
  logic [RND_W-1:0]   beat_x3;
  logic [RND_W-1:0]   base_d;
  logic [RND_W-1:0]   round1_d;
  logic [RND_W-1:0]   round2_d;
  logic [RK_W-1:0]    k0_c, k1_c, k2_c;
  beat_t              nxt_beat;
  beat_t              beat_out_q;
  logic               valid_q, busy_q, done_q;

  // Next state, beat index, latched key/mode and the base round of the beat to present next.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    key_d   = key_q;
    mode_d  = mode_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          key_d   = key_in;
          mode_d  = mode;
          beat_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          beat_d  = '0;
          state_d = IDLE;
        end else if (rk_ready) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = FIN;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    beat_x3 = RND_W'(beat_d) * RND_W'(KPB);
    base_d  = mode_d ? (RND_W'(ROUNDS - 2) - beat_x3) : (RND_W'(1) + beat_x3);
  end

  assign round1_d = base_d + RND_W'(1);
  assign round2_d = base_d + RND_W'(2);

  key_sched_lane u_lane0 (.key(key_d), .round(base_d),   .rk_c(k0_c));
  key_sched_lane u_lane1 (.key(key_d), .round(round1_d), .rk_c(k1_c));
  key_sched_lane u_lane2 (.key(key_d), .round(round2_d), .rk_c(k2_c));

  assign nxt_beat = '{round: base_d, rk0: k0_c, rk1: k1_c, rk2: k2_c};

  // Control state register; key resets to all-ones and only reloads on an accepted start.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      beat_q  <= '0;
      key_q   <= '1;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      key_q   <= key_d;
      mode_q  <= mode_d;
    end
  end

  // Registered outputs; payload is recomputed from unchanged state while stalled, so it holds.
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      beat_out_q <= '0;
    end else begin
      valid_q    <= (state_d == RUN);
      busy_q     <= (state_d == RUN);
      done_q     <= (state_d == FIN);
      beat_out_q <= (state_d == RUN) ? nxt_beat : '0;
    end
  end

  assign rk_valid = valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign rk_round = beat_out_q.round;
  assign rk0      = beat_out_q.rk0;
  assign rk1      = beat_out_q.rk1;
  assign rk2      = beat_out_q.rk2;

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Self-checking bench for key_sched_ctrl: directed scenarios plus randomized traffic vs a reference model.
module tb_key_sched_ctrl;

  logic         clk;
  logic         rst;
  logic         start;
  logic         mode;
  logic [127:0] key_in;
  logic         abort;
  logic         rk_ready;
  logic         rk_valid;
  logic [7:0]   rk0, rk1, rk2;
  logic [6:0]   rk_round;
  logic         busy;
  logic         done;

  int errors = 0;
  int checks = 0;

  // Reference model state: run flag, finish flag, beat index, latched key and direction.
  bit           m_run, m_fin, m_dec, m_rst;
  int           m_idx;
  logic [127:0] m_key;
  int           d_acc;
  int           d_done;

  localparam logic [127:0] KEY_SEQ = 128'h000102030405060708090A0B0C0D0E0F;

  key_sched_ctrl dut (
    .CLK(clk), .RST(rst), .start(start), .mode(mode), .key_in(key_in),
    .abort(abort), .rk_ready(rk_ready), .rk_valid(rk_valid),
    .rk0(rk0), .rk1(rk1), .rk2(rk2), .rk_round(rk_round),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Base round of beat idx: ascending triples for encrypt, descending triples for decrypt.
  function automatic int base_rnd(input int idx, input bit dec);
    return dec ? (96 - 2 - 3 * idx) : (1 + 3 * idx);
  endfunction

  // K_r from the key byte at position ((r mod 16) - 1) mod 16, MSB-first.
  function automatic logic [7:0] kref(input logic [127:0] k, input int r);
    int j;
    logic [127:0] sh;
    j  = ((r % 16) + 15) % 16;
    sh = k >> (8 * (15 - j));
    return 8'(r) ^ sh[7:0];
  endfunction

  // One clock: observe the handshake, advance the model, then compare after the edge.
  task automatic cycle();
    @(posedge clk);
    if (!rst && rk_valid && rk_ready && !abort) d_acc++;
    if (rst) begin
      m_run = 0; m_fin = 0; m_idx = 0; m_key = '1; m_rst = 1;
    end else begin
      m_rst = 0;
      if (m_run) begin
        if (abort) m_run = 0;
        else if (rk_ready) begin
          if (m_idx == 31) begin m_run = 0; m_fin = 1; end
          else m_idx++;
        end
      end else if (m_fin) begin
        m_fin = 0;
      end else if (start) begin
        m_run = 1; m_key = key_in; m_dec = mode; m_idx = 0;
      end
    end
    #1;
    if (done) d_done++;
    chk("valid", rk_valid, m_run);
    chk("busy", busy, m_run);
    chk("done", done, m_fin);
    if (m_run) begin
      chk("round", rk_round, 128'(base_rnd(m_idx, m_dec)));
      chk("rk0", rk0, kref(m_key, base_rnd(m_idx, m_dec)));
      chk("rk1", rk1, kref(m_key, base_rnd(m_idx, m_dec) + 1));
      chk("rk2", rk2, kref(m_key, base_rnd(m_idx, m_dec) + 2));
    end
    if (m_rst) begin
      chk("rst_round", rk_round, 0);
      chk("rst_rk", {rk0, rk1, rk2}, 0);
      chk("rst_key", dut.key_q, {128{1'b1}});
    end
  endtask

  // Clock until the model is back in idle; an expired budget counts as a failure.
  task automatic run_out(input int max);
    int n = 0;
    while ((m_run || m_fin) && n < max) begin
      cycle();
      n++;
    end
    chk("drain", 128'(m_run || m_fin), 0);
  endtask

  task automatic launch(input logic [127:0] k, input bit md);
    key_in = k; mode = md; start = 1; d_acc = 0; d_done = 0;
    cycle();
    start = 0;
  endtask

  initial begin
    rst = 1; start = 0; mode = 0; key_in = '0; abort = 0; rk_ready = 0;
    m_run = 0; m_fin = 0; m_dec = 0; m_rst = 0; m_idx = 0; m_key = '1;
    d_acc = 0; d_done = 0;
    cycle();
    cycle();
    rst = 0;
    cycle();

    // All-ones key, encrypt, continuous ready.
    rk_ready = 1;
    launch('1, 0);
    chk("t1_valid", rk_valid, 1);
    chk("t1_round", rk_round, 1);
    chk("t1_rk", {rk0, rk1, rk2}, 24'hFEFDFC);
    run_out(40);
    chk("t1_accepts", d_acc, 32);
    chk("t1_dones", d_done, 1);

    // Sequential key, encrypt: first beat and the j=15 wrap at round 16.
    launch(KEY_SEQ, 0);
    chk("t2_b0", {rk0, rk1, rk2}, 24'h010301);
    repeat (5) cycle();
    chk("t2_b5_round", rk_round, 16);
    chk("t2_b5", {rk0, rk1, rk2}, 24'h1F1113);
    run_out(40);

    // Sequential key, decrypt: descending beats ending at round 1.
    launch(KEY_SEQ, 1);
    chk("t3_round", rk_round, 94);
    chk("t3_b0", {rk0, rk1, rk2}, 24'h53516F);
    repeat (31) cycle();
    chk("t3_last_round", rk_round, 1);
    run_out(40);
    chk("t3_dones", d_done, 1);

    // Backpressure: ready low for 4 cycles mid-run.
    launch({$urandom(), $urandom(), $urandom(), $urandom()}, 0);
    repeat (6) cycle();
    rk_ready = 0;
    repeat (4) cycle();
    rk_ready = 1;
    run_out(40);
    chk("t4_accepts", d_acc, 32);
    chk("t4_dones", d_done, 1);

    // Abort coinciding with a handshake at beat 10.
    launch(KEY_SEQ, 0);
    repeat (10) cycle();
    chk("t5_round", rk_round, 31);
    abort = 1;
    cycle();
    abort = 0;
    chk("t5_valid", rk_valid, 0);
    cycle();
    chk("t5_nodone", d_done, 0);
    launch('1, 1);
    chk("t5_restart", rk_valid, 1);
    chk("t5_restart_round", rk_round, 94);
    run_out(40);

    // Start with a new key during a run is ignored; reset mid-run clears everything.
    launch(KEY_SEQ, 0);
    start = 1; key_in = '0; mode = 1;
    repeat (5) begin
      rk_ready = 1'($urandom_range(0, 1));
      cycle();
    end
    start = 0; rk_ready = 1;
    cycle();
    rst = 1;
    cycle();
    rst = 0;
    chk("t6_valid", rk_valid, 0);
    cycle();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 199) == 0);
      start    = ($urandom_range(0, 3) == 0);
      mode     = 1'($urandom_range(0, 1));
      key_in   = {$urandom(), $urandom(), $urandom(), $urandom()};
      abort    = ($urandom_range(0, 59) == 0);
      rk_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    rst = 0; start = 0; abort = 0; rk_ready = 1;
    run_out(80);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
